// File: rtl/rs_latch_pkg.sv
// Shared constants for rs_latch: encodings for resolving the S=R=1 condition.
package rs_latch_pkg;

    localparam int BOTH_HOLD  = 0;
    localparam int BOTH_RESET = 1;
    localparam int BOTH_SET   = 2;

    // Next state of a cell whose set and reset are both requested.
    function automatic logic resolve_both(input int mode, input logic q_cur);
        logic q_res;
        q_res = q_cur;
        case (mode)
            BOTH_RESET: q_res = 1'b0;
            BOTH_SET:   q_res = 1'b1;
            default:    q_res = q_cur;
        endcase
        return q_res;
    endfunction

endpackage

// File: rtl/rs_latch_sync.sv
// rs_sync: WIDTH-wide, SYNC_STAGES-deep flop chain; a plain wire when SYNC_STAGES is 0.
module rs_sync #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign q = d;
        end else begin : g_chain
            logic [WIDTH-1:0] chain_p [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) chain_p[k] <= '0;
                end else begin
                    chain_p[0] <= d;
                    for (int k = 1; k < SYNC_STAGES; k++) chain_p[k] <= chain_p[k-1];
                end
            end

            assign q = chain_p[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/rs_latch.sv
// Registered bank of RS cells with synchronous clear, optional input synchronizers
// and per-bit / sticky flags for the S=R=1 condition.
module rs_latch
    import rs_latch_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter int BOTH_MODE   = BOTH_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] illegal,
    output logic             illegal_err
);

    logic [WIDTH-1:0] ss;
    logic [WIDTH-1:0] rr;
    logic [WIDTH-1:0] both;
    logic             err_r;

    rs_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync_s (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (s),
        .q     (ss)
    );

    rs_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync_r (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (r),
        .q     (rr)
    );

    assign both = ss & rr;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            logic q_c;
            logic qn_c;
            logic ill_c;
            logic q_nxt;

            always_comb begin
                q_nxt = q_c;
                case ({ss[i], rr[i]})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   q_nxt = resolve_both(BOTH_MODE, q_c);
                    default: q_nxt = q_c;
                endcase
            end

            // qn is its own flop so q and qn never match, even through reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_c   <= 1'b0;
                    qn_c  <= 1'b1;
                    ill_c <= 1'b0;
                end else if (clr) begin
                    q_c   <= 1'b0;
                    qn_c  <= 1'b1;
                    ill_c <= 1'b0;
                end else begin
                    q_c   <= q_nxt;
                    qn_c  <= ~q_nxt;
                    ill_c <= both[i];
                end
            end

            assign q[i]       = q_c;
            assign qn[i]      = qn_c;
            assign illegal[i] = ill_c;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (clr) begin
            err_r <= 1'b0;
        end else if (|both) begin
            err_r <= 1'b1;
        end
    end

    assign illegal_err = err_r;

endmodule

// File: tb/tb_rs_latch.sv
// Bench for rs_latch: three 1-bit cells (one per BOTH_MODE) plus a 4-bit synchronized bank.
module tb_rs_latch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s1, r1, clr1;
    logic [2:0] q_all, qn_all, ill_all, err_all;
    logic [3:0] s4, r4, q4, qn4, ill4;
    logic       clr4, err4;

    rs_latch #(.WIDTH(1), .SYNC_STAGES(0), .BOTH_MODE(0)) dut_hold (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .clr(clr1),
        .q(q_all[0]), .qn(qn_all[0]), .illegal(ill_all[0]), .illegal_err(err_all[0])
    );
    rs_latch #(.WIDTH(1), .SYNC_STAGES(0), .BOTH_MODE(1)) dut_rdom (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .clr(clr1),
        .q(q_all[1]), .qn(qn_all[1]), .illegal(ill_all[1]), .illegal_err(err_all[1])
    );
    rs_latch #(.WIDTH(1), .SYNC_STAGES(0), .BOTH_MODE(2)) dut_sdom (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .clr(clr1),
        .q(q_all[2]), .qn(qn_all[2]), .illegal(ill_all[2]), .illegal_err(err_all[2])
    );
    rs_latch #(.WIDTH(4), .SYNC_STAGES(2), .BOTH_MODE(0)) dut_sync (
        .clk(clk), .rst_n(rst_n), .s(s4), .r(r4), .clr(clr4),
        .q(q4), .qn(qn4), .illegal(ill4), .illegal_err(err4)
    );

    typedef struct packed {
        logic [2:0] q;
        logic [2:0] ill;
        logic       err;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] sq4[$];
    logic [2:0] m_q;
    logic       m_err;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Drive one cycle of 1-bit stimulus and push the behavioural expectation.
    task automatic drive1(input logic s_i, input logic r_i, input logic c_i);
        exp_t e;
        s1 = s_i; r1 = r_i; clr1 = c_i;
        e.ill = 3'b000;
        for (int m = 0; m < 3; m++) begin
            if (c_i)             m_q[m] = 1'b0;
            else if (s_i && !r_i) m_q[m] = 1'b1;
            else if (!s_i && r_i) m_q[m] = 1'b0;
            else if (s_i && r_i) begin
                e.ill[m] = 1'b1;
                if (m == 1)      m_q[m] = 1'b0;
                else if (m == 2) m_q[m] = 1'b1;
            end
        end
        if (c_i)              m_err = 1'b0;
        else if (s_i && r_i)  m_err = 1'b1;
        e.q   = m_q;
        e.err = m_err;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s1 = 0; r1 = 0; clr1 = 0; s4 = 0; r4 = 0; clr4 = 0;
        m_q = 3'b000; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (q_all !== 3'b000) begin n_bad++; $display("FAIL reset_q got %b want 000", q_all); end
        n_cmp++; if (qn_all !== 3'b111) begin n_bad++; $display("FAIL reset_qn got %b want 111", qn_all); end
        n_cmp++; if (ill_all !== 3'b000 || err_all !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b/%b want 000/000", ill_all, err_all); end
        n_cmp++; if (q4 !== 4'h0 || qn4 !== 4'hF || err4 !== 1'b0) begin n_bad++; $display("FAIL reset_sync got q=%h qn=%h err=%b want 0/f/0", q4, qn4, err4); end
        rst_n = 1'b1;
    endtask

    task automatic test_set_hold_reset();
        logic [2:0] seq [7] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
        exp_t e;
        for (int k = 0; k < 7; k++) begin
            drive1(seq[k][2], seq[k][1], seq[k][0]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++; if (q_all !== e.q) begin n_bad++; $display("FAIL shr_q[%0d] got %b want %b", k, q_all, e.q); end
            n_cmp++; if (qn_all !== ~e.q) begin n_bad++; $display("FAIL shr_qn[%0d] got %b want %b", k, qn_all, ~e.q); end
            n_cmp++; if (ill_all !== e.ill) begin n_bad++; $display("FAIL shr_ill[%0d] got %b want %b", k, ill_all, e.ill); end
            n_cmp++; if (err_all !== {3{e.err}}) begin n_bad++; $display("FAIL shr_err[%0d] got %b want %b", k, err_all, {3{e.err}}); end
        end
    endtask

    task automatic test_both_and_clear();
        logic [2:0] seq [9] = '{3'b100, 3'b110, 3'b000, 3'b110, 3'b100, 3'b110,
                                3'b111, 3'b100, 3'b101};
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            drive1(seq[k][2], seq[k][1], seq[k][0]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++; if (q_all !== e.q) begin n_bad++; $display("FAIL both_q[%0d] got %b want %b", k, q_all, e.q); end
            n_cmp++; if (qn_all !== ~e.q) begin n_bad++; $display("FAIL both_qn[%0d] got %b want %b", k, qn_all, ~e.q); end
            n_cmp++; if (ill_all !== e.ill) begin n_bad++; $display("FAIL both_ill[%0d] got %b want %b", k, ill_all, e.ill); end
            n_cmp++; if (err_all !== {3{e.err}}) begin n_bad++; $display("FAIL both_err[%0d] got %b want %b", k, err_all, {3{e.err}}); end
        end
    endtask

    task automatic test_toggle();
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            drive1(k[0], ~k[0], (k % 4) == 3);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++; if (q_all !== e.q) begin n_bad++; $display("FAIL tog_q[%0d] got %b want %b", k, q_all, e.q); end
            n_cmp++; if (qn_all !== ~q_all) begin n_bad++; $display("FAIL tog_qn[%0d] got %b want %b", k, qn_all, ~q_all); end
            n_cmp++; if (ill_all !== e.ill) begin n_bad++; $display("FAIL tog_ill[%0d] got %b want %b", k, ill_all, e.ill); end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive1(1'b1, 1'b0, 1'b0); s4 = 4'hF;
        @(posedge clk); #1;
        e = sbq.pop_front();
        n_cmp++; if (q_all !== e.q) begin n_bad++; $display("FAIL arst_pre_q got %b want %b", q_all, e.q); end
        drive1(1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = sbq.pop_front();
        n_cmp++; if (err_all !== {3{e.err}}) begin n_bad++; $display("FAIL arst_pre_err got %b want %b", err_all, {3{e.err}}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (q_all !== 3'b000 || qn_all !== 3'b111) begin n_bad++; $display("FAIL arst_q got q=%b qn=%b want 000/111", q_all, qn_all); end
        n_cmp++; if (err_all !== 3'b000 || ill_all !== 3'b000) begin n_bad++; $display("FAIL arst_flags got err=%b ill=%b want 000/000", err_all, ill_all); end
        m_q = 3'b000; m_err = 1'b0;
        s1 = 0; r1 = 0; s4 = 4'h0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (q4 !== 4'h0 || qn4 !== 4'hF) begin n_bad++; $display("FAIL arst_sync_discard got q=%h qn=%h want 0/f", q4, qn4); end
    endtask

    task automatic test_sync_latency();
        logic [3:0] e4;
        for (int k = 0; k < 10; k++) begin
            s4 = (k < 2) ? 4'b0101 : 4'b0000;
            r4 = (k >= 4 && k < 6) ? 4'b0001 : 4'b0000;
            sq4.push_back((k >= 6) ? 4'b0100 : (k >= 2) ? 4'b0101 : 4'b0000);
            @(posedge clk); #1;
            e4 = sq4.pop_front();
            n_cmp++; if (q4 !== e4) begin n_bad++; $display("FAIL sync_q[%0d] got %b want %b", k, q4, e4); end
            n_cmp++; if (qn4 !== ~e4) begin n_bad++; $display("FAIL sync_qn[%0d] got %b want %b", k, qn4, ~e4); end
            n_cmp++; if (ill4 !== 4'b0000 || err4 !== 1'b0) begin n_bad++; $display("FAIL sync_flags[%0d] got %b/%b want 0000/0", k, ill4, err4); end
        end
    endtask

    initial begin
        test_reset();
        test_set_hold_reset();
        test_both_and_clear();
        test_toggle();
        test_async_reset();
        test_sync_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
